// File: rtl/fifo_arbiter.sv
// Round-robin scheduler moving words from four input FIFOs to four output FIFOs by destination
// field, throttled by output almost-full flags; also holds the FIFO threshold configuration.
module fifo_arbiter #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DATA_W        = 6,
  parameter int unsigned DEST_LSB      = 4,
  parameter logic [2:0]  UMB_VACIO_RST = 3'd1,
  parameter logic [2:0]  UMB_LLENO_RST = 3'd6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [2:0]               umbral_vacio_in,
  input  logic [2:0]               umbral_lleno_in,
  input  logic [N_CH-1:0]          in_empty,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          out_almost_full,
  input  logic [N_CH-1:0]          out_full,
  output logic [N_CH-1:0]          in_pop,
  output logic [N_CH-1:0]          out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               umbral_vacio,
  output logic [2:0]               umbral_lleno,
  output logic [1:0]               state,
  output logic                     error
);

  typedef enum logic [1:0] {
    StReset  = 2'd0,
    StInit   = 2'd1,
    StIdle   = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_CH-1:0]     in_pop_q, out_push_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [2:0]          umbral_vacio_q, umbral_lleno_q;
  logic                error_q;
  logic [1:0]          last_grant_q;
  logic                rd_valid_q;
  logic [1:0]          rd_ch_q;

  logic                any_req, any_af;
  logic [N_CH-1:0]     eligible;
  logic [N_CH-1:0]     grant;
  logic [1:0]          grant_idx;
  logic [1:0]          scan_idx;
  logic                found;
  logic [DATA_W-1:0]   rd_word;
  logic [1:0]          rd_dest;
  logic                drop;
  logic [N_CH-1:0]     push_d;
  logic                init_entry;

  assign any_req  = ~&in_empty;
  assign any_af   = |out_almost_full;
  // A channel popped this cycle still shows non-empty until its FIFO updates.
  assign eligible = ~in_empty & ~in_pop_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = StIdle;
      StIdle: begin
        if (init) state_d = StInit;
        else if (any_req && !any_af) state_d = StActive;
      end
      StActive: begin
        if (init) state_d = StInit;
        else if (!any_req || any_af) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    scan_idx  = '0;
    found     = 1'b0;
    if (state_d == StActive) begin
      for (int i = 1; i <= N_CH; i++) begin
        scan_idx = last_grant_q + 2'(i);
        if (!found && eligible[scan_idx]) begin
          found           = 1'b1;
          grant_idx       = scan_idx;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign rd_word    = in_data[int'(rd_ch_q) * DATA_W +: DATA_W];
  assign rd_dest    = rd_word[DEST_LSB +: 2];
  assign drop       = rd_valid_q & out_full[rd_dest];
  assign push_d     = (rd_valid_q && !out_full[rd_dest]) ? (N_CH'(1) << rd_dest) : '0;
  assign init_entry = (state_d == StInit) && (state_q != StInit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StReset;
      in_pop_q       <= '0;
      out_push_q     <= '0;
      out_data_q     <= '0;
      umbral_vacio_q <= UMB_VACIO_RST;
      umbral_lleno_q <= UMB_LLENO_RST;
      error_q        <= 1'b0;
      last_grant_q   <= 2'd3;
      rd_valid_q     <= 1'b0;
      rd_ch_q        <= '0;
    end else begin
      state_q    <= state_d;
      in_pop_q   <= grant;
      if (found) last_grant_q <= grant_idx;
      // last_grant_q names the channel whose pop strobe is high this cycle.
      rd_valid_q <= |in_pop_q;
      rd_ch_q    <= last_grant_q;
      out_push_q <= push_d;
      if (rd_valid_q && !drop) out_data_q <= rd_word;
      if (state_q == StInit) begin
        umbral_vacio_q <= umbral_vacio_in;
        umbral_lleno_q <= umbral_lleno_in;
      end
      if (drop) error_q <= 1'b1;
      else if (init_entry) error_q <= 1'b0;
    end
  end

  assign in_pop       = in_pop_q;
  assign out_push     = out_push_q;
  assign out_data     = out_data_q;
  assign umbral_vacio = umbral_vacio_q;
  assign umbral_lleno = umbral_lleno_q;
  assign state        = state_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Randomized bench for fifo_arbiter: queue-based FIFO environment, behavioural model of the
// scheduling rules, and a scoreboard monitor for the output pushes.
module tb_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset, init;
  logic [2:0]  uv_in, ul_in;
  logic [3:0]  in_empty, af, full;
  logic [23:0] in_data;
  logic [3:0]  in_pop, out_push;
  logic [5:0]  out_data;
  logic [2:0]  umbral_vacio, umbral_lleno;
  logic [1:0]  state;
  logic        error;

  always #5 clk = ~clk;

  fifo_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_vacio_in (uv_in),
    .umbral_lleno_in (ul_in),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .out_almost_full (af),
    .out_full        (full),
    .in_pop          (in_pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .umbral_vacio    (umbral_vacio),
    .umbral_lleno    (umbral_lleno),
    .state           (state),
    .error           (error)
  );

  typedef struct {
    int         cyc;
    logic [3:0] push;
    logic [5:0] data;
  } exp_t;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  logic [5:0] env_q[4][$];
  logic [5:0] mdl_q[4][$];
  logic [3:0] env_pend = '0;

  // Reference model state: values the DUT should present during the current cycle.
  int         m_state = 0;
  int         m_last = 3;
  int         m_pop_ch = -1;
  bit         m_cap_valid = 1'b0;
  logic [5:0] m_cap_word = '0;
  logic [2:0] m_vac = 3'd1;
  logic [2:0] m_lle = 3'd6;
  bit         m_err = 1'b0;
  logic [5:0] m_odata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void refresh();
    for (int k = 0; k < 4; k++) in_empty[k] = (env_q[k].size() == 0);
  endfunction

  task automatic push_word(input int k, input logic [5:0] w);
    env_q[k].push_back(w);
    mdl_q[k].push_back(w);
    refresh();
  endtask

  // Advance one clock; the environment FIFOs honour the pop strobe seen during the last cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (env_pend[k] && env_q[k].size() > 0) in_data[k*6 +: 6] = env_q[k].pop_front();
    end
    env_pend = '0;
    refresh();
  endtask

  task automatic model_step();
    logic [3:0] elig;
    int         nxt, kk;
    bit         any_ne, any_af, drop_set, new_cap;
    logic [5:0] new_word;
    exp_t       e;
    chk("state", 32'(state), 32'(m_state));
    chk("in_pop", 32'(in_pop), (m_pop_ch < 0) ? 32'd0 : (32'd1 << m_pop_ch));
    chk("umbral_vacio", 32'(umbral_vacio), 32'(m_vac));
    chk("umbral_lleno", 32'(umbral_lleno), 32'(m_lle));
    chk("error", 32'(error), 32'(m_err));
    chk("out_data", 32'(out_data), 32'(m_odata));
    env_pend = in_pop;
    any_ne = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mdl_q[k].size() != 0) any_ne = 1'b1;
      elig[k] = (mdl_q[k].size() != 0) && (m_pop_ch != k);
    end
    any_af = |af;
    case (m_state)
      0:       nxt = 1;
      1:       nxt = init ? 1 : 2;
      2:       nxt = init ? 1 : ((any_ne && !any_af) ? 3 : 2);
      default: nxt = init ? 1 : ((!any_ne || any_af) ? 2 : 3);
    endcase
    new_cap  = 1'b0;
    new_word = '0;
    if (m_pop_ch >= 0 && mdl_q[m_pop_ch].size() > 0) begin
      new_word = mdl_q[m_pop_ch].pop_front();
      new_cap  = 1'b1;
    end
    drop_set = 1'b0;
    if (!reset) begin
      m_state = 0; m_pop_ch = -1; m_last = 3; m_cap_valid = 1'b0;
      m_vac = 3'd1; m_lle = 3'd6; m_err = 1'b0; m_odata = '0;
    end else begin
      if (m_cap_valid) begin
        if (full[m_cap_word[5:4]]) drop_set = 1'b1;
        else begin
          e.cyc  = cyc + 1;
          e.push = 4'b0001 << m_cap_word[5:4];
          e.data = m_cap_word;
          sb.push_back(e);
          m_odata = m_cap_word;
        end
      end
      if (m_state == 1) begin
        m_vac = uv_in;
        m_lle = ul_in;
      end
      if (drop_set) m_err = 1'b1;
      else if (nxt == 1 && m_state != 1) m_err = 1'b0;
      m_pop_ch = -1;
      if (nxt == 3) begin
        for (int i = 1; i <= 4; i++) begin
          kk = (m_last + i) % 4;
          if (m_pop_ch < 0 && elig[kk]) m_pop_ch = kk;
        end
      end
      if (m_pop_ch >= 0) m_last = m_pop_ch;
      m_cap_valid = new_cap;
      m_cap_word  = new_word;
      m_state     = nxt;
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (out_push !== 4'b0000) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        chk("unexpected_push", 32'(out_push), 32'd0);
      end else begin
        chk("push_dest", 32'(out_push), 32'(sb[0].push));
        chk("push_data", 32'(out_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      chk("missing_push", 32'(out_push), 32'(sb[0].push));
      void'(sb.pop_front());
    end
  end

  initial begin
    bit seen;
    reset = 1'b0; init = 1'b1; uv_in = 3'd2; ul_in = 3'd5;
    af = '0; full = '0; in_data = '0;
    refresh();
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    init = 1'b0;
    repeat (3) tick();
    chk("cfg_vacio", 32'(umbral_vacio), 32'd2);
    chk("cfg_lleno", 32'(umbral_lleno), 32'd5);
    chk("cfg_state_idle", 32'(state), 32'd2);

    // All four channels loaded, no backpressure.
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) push_word(k, {2'((j + k) % 4), 4'($urandom_range(0, 15))});
    repeat (20) tick();

    // Single channel: alternate-cycle pops.
    push_word(2, 6'h35);
    push_word(2, 6'h05);
    repeat (12) tick();

    // Almost-full backpressure mid-stream.
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) push_word(k, 6'($urandom_range(0, 63)));
    repeat (3) tick();
    af = 4'b0010;
    repeat (4) tick();
    af = '0;
    repeat (15) tick();

    // Drop on full destination; error stays until INIT.
    full = 4'b1000;
    push_word(1, 6'h3A);
    repeat (6) tick();
    full = '0;
    repeat (4) tick();
    chk("error_sticky", 32'(error), 32'd1);
    init = 1'b1;
    repeat (2) tick();
    chk("error_cleared", 32'(error), 32'd0);
    init = 1'b0;
    repeat (3) tick();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      tick();
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        if (env_q[k].size() < 6) push_word(k, 6'($urandom_range(0, 63)));
      end
      if ($urandom_range(0, 7) == 0) af = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      full = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
    end
    af = '0; full = '0;
    repeat (30) tick();

    // Reset one cycle after a pop.
    push_word(0, 6'h12);
    push_word(3, 6'h27);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (in_pop != 4'b0000) seen = 1'b1;
    end
    if (!seen) chk("pop_timeout", 32'd0, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_pop", 32'(in_pop), 32'd0);
    chk("rst_out_push", 32'(out_push), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_vacio", 32'(umbral_vacio), 32'd1);
    chk("rst_lleno", 32'(umbral_lleno), 32'd6);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    repeat (30) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Round-robin scheduler between four 6-bit input FIFOs and four output FIFOs in the switch datapath. It pops one word at a time from a non-empty input FIFO and routes it to the output FIFO selected by the destination field (bits [5:4]). It throttles on the output FIFOs' almost-full flags. It also holds the threshold (umbral) configuration distributed to all FIFO instances.

## Interface
- N_CH, 4, number of input and output channels (fixed at 4; grant and destination are 2 bits)
- DATA_W, 6, word width
- DEST_LSB, 4, LSB of the 2-bit destination field inside the word
- UMB_VACIO_RST, 3'd1, reset value of the empty threshold
- UMB_LLENO_RST, 3'd6, reset value of the full threshold

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- init  in  1  configuration strobe, level-sensitive
- umbral_vacio_in  in  3  empty-threshold value, sampled while in INIT
- umbral_lleno_in  in  3  full-threshold value, sampled while in INIT
- in_empty  in  4  empty flags of the input FIFOs
- in_data  in  24  input FIFO read data, channel k at [6k+5:6k], valid the cycle after its pop
- out_almost_full  in  4  almost-full flags of the output FIFOs
- out_full  in  4  full flags of the output FIFOs
- in_pop  out  4  registered one-hot read strobe to the input FIFOs
- out_push  out  4  registered one-hot write strobe to the output FIFOs
- out_data  out  6  registered word to the output FIFOs
- umbral_vacio  out  3  distributed empty threshold
- umbral_lleno  out  3  distributed full threshold
- state  out  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3
- error  out  1  sticky overflow flag

## Operation
- **FSM transitions:**
  - RESET → INIT on the first clock with reset=1.
  - INIT → IDLE when init=0.
  - IDLE → ACTIVE when any in_empty=0 and all out_almost_full=0.
  - ACTIVE → IDLE when all in_empty=1, or any out_almost_full=1.
  - IDLE or ACTIVE → INIT when init=1.
- **INIT:** umbral_vacio and umbral_lleno load from the *_in inputs on every clock. No pops are issued.
- **Pop eligibility:** a pop is issued only when the next state is ACTIVE. Channel k is eligible iff in_empty[k]=0 and k was not popped in the previous cycle. That anti-underflow rule limits each channel to one pop per 2 cycles. Aggregate throughput is 1 pop/cycle when 2 or more channels are eligible.
- **Round-robin:** the search starts at (last_grant+1) mod 4, then increments. last_grant resets to 3, so channel 0 has first priority.
- **Backpressure:** blocking. Any out_almost_full=1 stops all pops, which causes head-of-line stall. Words already in flight (at most 2) still complete. lleno thresholds must leave 2 free slots.
- **Routing:** dest = word[DEST_LSB+1:DEST_LSB].
  - out_push[dest]=1 and out_data=word, with the word unmodified.
  - If out_full[dest]=1 in the capture cycle, the word is dropped (no push) and error is set.
- **error:** sticky. It clears only on reset or on entry to INIT.

## Timing
- **Reset values:** in_pop=0, out_push=0, out_data=0, umbral_vacio=UMB_VACIO_RST, umbral_lleno=UMB_LLENO_RST, state=RESET, error=0, last_grant=3, pipeline valid=0.
- **Pop-to-push pipeline:**
  - Cycle t: in_pop[k]=1.
  - Cycle t+1: in_data[k] is captured with its dest.
  - Cycle t+2: out_push[dest]=1, out_data valid for exactly 1 cycle.
  - Pop-to-push latency is 2 cycles.
- **Strobes:** in_pop and out_push are each one-hot or zero, and high for 1 cycle per word.
- **Simultaneous events:**
  - init=1 while words are in flight: the in-flight words still push.
  - out_almost_full rising in the same cycle as an eligible request: no pop is issued that cycle, because the decision uses current inputs.
- **Reset mid-operation:** takes effect on the next edge. In-flight words are discarded (no push) and all outputs return to reset values.
- **Wrap-around:** the round-robin pointer goes 3 → 0.
- **Threshold outputs:** change only on clock edges in INIT and are stable otherwise.

## Test plan
- Release reset with init=1, umbral_*_in=2/5, then drop init → umbral_vacio=2, umbral_lleno=5, state goes 0 → 1 → 2.
- All four FIFOs non-empty, no backpressure → in_pop sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles. Each word appears on out_push 2 cycles after its pop.
- Only channel 2 non-empty holding words 6'h35 and 6'h05 → pops on alternate cycles. Out sees out_push=1000 with 6'h35, then 0001 with 6'h05.
- out_almost_full[1]=1 mid-stream → in_pop=0 from that cycle. The 2 in-flight words still push, and popping resumes the cycle after the flag drops.
- Word with dest=3 while out_full[3]=1 at capture → no out_push, error=1 and held, until init=1 clears it.
- Assert reset 1 cycle after a pop → no out_push follows, and all outputs are at reset values the next cycle.
